// File: rtl/plic_claim_master_pkg.sv
// plic_claim_master_pkg: mem_if types, bus widths and the claim FSM state encoding.
package plic_claim_master_pkg;
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_MASK_W = MEM_DATA_W / 8;
  localparam logic [MEM_ADDR_W-1:0] PLIC_BASE_DEF = 32'h0C00_0000;
  typedef enum logic {MEM_READ = 1'b0, MEM_WRITE = 1'b1} mem_type_e;
  typedef struct packed {
    logic [MEM_ADDR_W-1:0] req_addr;
    logic [MEM_DATA_W-1:0] req_data;
    logic [MEM_MASK_W-1:0] req_mask;
    mem_type_e             req_type;
  } mem_req_t;
  typedef struct packed {
    logic [MEM_DATA_W-1:0] resp_data;
    logic                  resp_last;
  } mem_resp_t;
  typedef enum logic [3:0] {
    IDLE, CLAIM_REQ, CLAIM_RESP, DELIVER, WAIT_DONE, CMPL_REQ, CMPL_RESP, INIT_REQ, INIT_RESP
  } plic_claim_state_e;
endpackage

// File: rtl/plic_claim_master.sv
// plic_claim_master: claims PLIC interrupts over mem_if, hands ids to the core, writes completions back.
// PLIC_CLAIM_THRES_INIT_EN: after reset, write PLIC_THRES_INIT to the threshold register before servicing.
module plic_claim_master
  import plic_claim_master_pkg::*;
#(
  parameter logic [MEM_ADDR_W-1:0] PLIC_BASE = PLIC_BASE_DEF,
  parameter int PLIC_IRQ_N = 32,
  parameter int PLIC_CLAIM_W = $clog2(PLIC_IRQ_N + 1),
  parameter int PLIC_THRES_INIT = 0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    ext_irq,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output mem_req_t                mem_req,
  input  logic                    mem_resp_valid,
  output logic                    mem_resp_ready,
  input  mem_resp_t               mem_resp,
  output logic                    irq_valid,
  input  logic                    irq_ready,
  output logic [PLIC_CLAIM_W-1:0] irq_id,
  input  logic                    irq_done,
  output logic                    busy
);
  localparam logic [MEM_ADDR_W-1:0] CLAIM_ADDR = PLIC_BASE + MEM_ADDR_W'((PLIC_IRQ_N + 3) * 4);
`ifdef PLIC_CLAIM_THRES_INIT_EN
  localparam logic [MEM_ADDR_W-1:0] THRES_ADDR = PLIC_BASE + MEM_ADDR_W'((PLIC_IRQ_N + 2) * 4);
  localparam plic_claim_state_e RST_STATE = INIT_REQ;
`else
  localparam plic_claim_state_e RST_STATE = IDLE;
`endif
  plic_claim_state_e r_state, w_next;
  logic [PLIC_CLAIM_W-1:0] r_id;
  logic [PLIC_CLAIM_W-1:0] w_resp_id;
  logic w_unused;
  assign w_resp_id = mem_resp.resp_data[PLIC_CLAIM_W-1:0];
  assign w_unused = ^{mem_resp, PLIC_THRES_INIT};
  assign busy = r_state != IDLE;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= RST_STATE;
      r_id    <= '0;
    end else begin
      r_state <= w_next;
      r_id    <= (r_state == CLAIM_RESP && mem_resp_valid) ? w_resp_id : r_id;
    end
  end
  always_comb begin
    w_next         = r_state;
    mem_req_valid  = 1'b0;
    mem_req        = '0;
    mem_resp_ready = 1'b0;
    irq_valid      = 1'b0;
    irq_id         = '0;
    case (r_state)
      IDLE: w_next = ext_irq ? CLAIM_REQ : IDLE;
      CLAIM_REQ: begin
        mem_req_valid    = 1'b1;
        mem_req.req_addr = CLAIM_ADDR;
        mem_req.req_mask = '1;
        mem_req.req_type = MEM_READ;
        w_next           = mem_req_ready ? CLAIM_RESP : CLAIM_REQ;
      end
      CLAIM_RESP: begin
        mem_resp_ready = 1'b1;
        w_next         = !mem_resp_valid ? CLAIM_RESP : (w_resp_id == '0) ? IDLE : DELIVER;
      end
      DELIVER: begin
        irq_valid = 1'b1;
        irq_id    = r_id;
        w_next    = irq_ready ? WAIT_DONE : DELIVER;
      end
      WAIT_DONE: w_next = irq_done ? CMPL_REQ : WAIT_DONE;
      CMPL_REQ: begin
        mem_req_valid    = 1'b1;
        mem_req.req_addr = CLAIM_ADDR;
        mem_req.req_data = MEM_DATA_W'(r_id);
        mem_req.req_mask = '1;
        mem_req.req_type = MEM_WRITE;
        w_next           = mem_req_ready ? CMPL_RESP : CMPL_REQ;
      end
      CMPL_RESP: begin
        mem_resp_ready = 1'b1;
        w_next         = mem_resp_valid ? IDLE : CMPL_RESP;
      end
`ifdef PLIC_CLAIM_THRES_INIT_EN
      INIT_REQ: begin
        mem_req_valid    = 1'b1;
        mem_req.req_addr = THRES_ADDR;
        mem_req.req_data = MEM_DATA_W'(PLIC_THRES_INIT);
        mem_req.req_mask = '1;
        mem_req.req_type = MEM_WRITE;
        w_next           = mem_req_ready ? INIT_RESP : INIT_REQ;
      end
      INIT_RESP: begin
        mem_resp_ready = 1'b1;
        w_next         = mem_resp_valid ? IDLE : INIT_RESP;
      end
`endif
      default: w_next = RST_STATE;
    endcase
  end
endmodule

// File: tb/tb_plic_claim_master.sv
// tb_plic_claim_master: directed tests against a small PLIC claim/priority model and 1-cycle mem_if responder.
module tb_plic_claim_master;
  import plic_claim_master_pkg::*;
  localparam logic [31:0] CLAIM_A = 32'h0C00_008C;
  localparam logic [31:0] THRES_A = 32'h0C00_0088;
  logic clk = 1'b0;
  logic rstn, ext_irq, ext_force;
  logic mem_req_valid, mem_req_ready, mem_resp_valid, mem_resp_ready;
  mem_req_t mem_req;
  mem_resp_t mem_resp;
  logic irq_valid, irq_ready, irq_done, busy;
  logic [5:0] irq_id;
  logic [31:0] pend_tog, clm_tog = '0;
  int prio [32];
  logic [5:0] best_id;
  logic resp_pend = 1'b0, resp_stall;
  logic [31:0] resp_dat = '0;
  logic [31:0] log_addr [64];
  logic [31:0] log_data [64];
  mem_type_e log_type [64];
  int n_req = 0;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  plic_claim_master #(.PLIC_THRES_INIT(3)) dut (
    .clk(clk), .rstn(rstn), .ext_irq(ext_irq),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req(mem_req),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp(mem_resp),
    .irq_valid(irq_valid), .irq_ready(irq_ready), .irq_id(irq_id), .irq_done(irq_done), .busy(busy)
  );
  function automatic logic [5:0] best(input logic [31:0] p);
    logic [5:0] b = '0;
    int bp = -1;
    for (int i = 1; i < 32; i++)
      if (p[i] && prio[i] > bp) begin
        b = 6'(i);
        bp = prio[i];
      end
    return b;
  endfunction
  always_comb best_id = best(pend_tog ^ clm_tog);
  assign ext_irq = ext_force | (|(pend_tog ^ clm_tog));
  assign mem_resp_valid = resp_pend & ~resp_stall;
  assign mem_resp = '{resp_data: resp_dat, resp_last: 1'b1};
  always @(posedge clk or negedge rstn) begin
    if (!rstn) resp_pend <= 1'b0;
    else begin
      if (mem_resp_valid && mem_resp_ready) resp_pend <= 1'b0;
      if (mem_req_valid && mem_req_ready) begin
        log_addr[n_req] <= mem_req.req_addr;
        log_data[n_req] <= mem_req.req_data;
        log_type[n_req] <= mem_req.req_type;
        n_req <= n_req + 1;
        resp_pend <= 1'b1;
        if (mem_req.req_type == MEM_READ) begin
          resp_dat <= 32'(best_id);
          if (best_id != 0) clm_tog[best_id[4:0]] <= ~clm_tog[best_id[4:0]];
        end else resp_dat <= 32'hDEAD_BEEF;
      end
    end
  end
  task automatic tick(); @(negedge clk); endtask
  task automatic wait_idle(); for (int i = 0; i < 30 && busy !== 1'b0; i++) tick(); endtask
  task automatic wait_valid(); for (int i = 0; i < 30 && irq_valid !== 1'b1; i++) tick(); endtask
  task automatic raise(input int id, input int p); prio[id] = p; pend_tog[id] = ~pend_tog[id]; endtask
  task automatic ack(); irq_ready = 1'b1; tick(); irq_ready = 1'b0; endtask
  task automatic done(); irq_done = 1'b1; tick(); irq_done = 1'b0; endtask
  task automatic test_reset();
    repeat (2) tick();
    total++; if (irq_valid !== 1'b0) $display("FAIL rst_irq_valid got %b want 0", irq_valid); else passed++;
    total++; if (irq_id !== 6'd0) $display("FAIL rst_irq_id got %0d want 0", irq_id); else passed++;
    total++; if (mem_resp_ready !== 1'b0) $display("FAIL rst_resp_ready got %b want 0", mem_resp_ready); else passed++;
`ifdef PLIC_CLAIM_THRES_INIT_EN
    total++; if (busy !== 1'b1) $display("FAIL rst_busy got %b want 1", busy); else passed++;
    rstn = 1'b1;
    wait_idle();
    total++; if (n_req !== 1) $display("FAIL init_count got %0d want 1", n_req); else passed++;
    total++; if (log_addr[0] !== THRES_A || log_data[0] !== 32'd3 || log_type[0] !== MEM_WRITE)
      $display("FAIL init_write got %h/%h/%0d want %h/3/WRITE", log_addr[0], log_data[0], log_type[0], THRES_A); else passed++;
`else
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passed++;
    total++; if (mem_req_valid !== 1'b0 || mem_req !== '0) $display("FAIL rst_req got %b/%h want 0", mem_req_valid, mem_req); else passed++;
    rstn = 1'b1;
    repeat (3) tick();
    total++; if (n_req !== 0 || busy !== 1'b0) $display("FAIL rst_quiet got n=%0d busy=%b want 0/0", n_req, busy); else passed++;
`endif
  endtask
  task automatic test_basic();
    int base = n_req;
    raise(5, 1);
    tick();
    total++; if (mem_req_valid !== 1'b1 || irq_valid !== 1'b0) $display("FAIL basic_c1 got v=%b iv=%b want 1/0", mem_req_valid, irq_valid); else passed++;
    tick();
    total++; if (irq_valid !== 1'b0 || mem_resp_ready !== 1'b1) $display("FAIL basic_c2 got iv=%b rr=%b want 0/1", irq_valid, mem_resp_ready); else passed++;
    tick();
    total++; if (irq_valid !== 1'b1 || irq_id !== 6'd5) $display("FAIL basic_c3 got iv=%b id=%0d want 1/5", irq_valid, irq_id); else passed++;
    ack();
    done();
    wait_idle();
    total++; if (busy !== 1'b0) $display("FAIL basic_idle got busy=%b want 0", busy); else passed++;
    total++; if (n_req !== base + 2) $display("FAIL basic_count got %0d want %0d", n_req - base, 2); else passed++;
    total++; if (log_addr[base] !== CLAIM_A || log_type[base] !== MEM_READ) $display("FAIL basic_read got %h/%0d want %h/READ", log_addr[base], log_type[base], CLAIM_A); else passed++;
    total++; if (log_addr[base+1] !== CLAIM_A || log_type[base+1] !== MEM_WRITE || log_data[base+1] !== 32'd5)
      $display("FAIL basic_write got %h/%0d/%h want %h/WRITE/5", log_addr[base+1], log_type[base+1], log_data[base+1], CLAIM_A); else passed++;
  endtask
  task automatic test_spurious();
    int base = n_req;
    logic saw = 1'b0;
    ext_force = 1'b1;
    tick();
    ext_force = 1'b0;
    for (int i = 0; i < 20 && busy !== 1'b0; i++) begin
      saw = saw | irq_valid;
      tick();
    end
    repeat (2) tick();
    total++; if (saw !== 1'b0) $display("FAIL spur_deliver got 1 want 0"); else passed++;
    total++; if (busy !== 1'b0 || mem_req_valid !== 1'b0) $display("FAIL spur_idle got busy=%b v=%b want 0/0", busy, mem_req_valid); else passed++;
    total++; if (n_req !== base + 1 || log_type[base] !== MEM_READ) $display("FAIL spur_reqs got %0d want 1 read", n_req - base); else passed++;
  endtask
  task automatic test_stall();
    int base = n_req;
    mem_req_ready = 1'b0;
    raise(9, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      total++; if (mem_req_valid !== 1'b1 || mem_req.req_addr !== CLAIM_A || mem_req.req_type !== MEM_READ || mem_req.req_data !== 32'd0 || mem_req.req_mask !== 4'hF)
        $display("FAIL stall_claim got v=%b %h/%0d/%h want 1 %h/READ/0", mem_req_valid, mem_req.req_addr, mem_req.req_type, mem_req.req_data, CLAIM_A); else passed++;
      tick();
    end
    mem_req_ready = 1'b1;
    wait_valid();
    total++; if (irq_id !== 6'd9) $display("FAIL stall_id got %0d want 9", irq_id); else passed++;
    ack();
    mem_req_ready = 1'b0;
    done();
    for (int i = 0; i < 4; i++) begin
      total++; if (mem_req_valid !== 1'b1 || mem_req.req_addr !== CLAIM_A || mem_req.req_type !== MEM_WRITE || mem_req.req_data !== 32'd9)
        $display("FAIL stall_cmpl got v=%b %h/%0d/%h want 1 %h/WRITE/9", mem_req_valid, mem_req.req_addr, mem_req.req_type, mem_req.req_data, CLAIM_A); else passed++;
      tick();
    end
    mem_req_ready = 1'b1;
    wait_idle();
    total++; if (n_req !== base + 2) $display("FAIL stall_count got %0d want 2", n_req - base); else passed++;
  endtask
  task automatic test_deliver_delay();
    int base = n_req;
    raise(12, 1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      irq_done = (i == 2);
      tick();
      total++; if (irq_valid !== 1'b1 || irq_id !== 6'd12) $display("FAIL dly_hold got iv=%b id=%0d want 1/12", irq_valid, irq_id); else passed++;
    end
    irq_ready = 1'b1;
    irq_done = 1'b1;
    tick();
    irq_ready = 1'b0;
    irq_done = 1'b0;
    repeat (3) tick();
    total++; if (busy !== 1'b1 || mem_req_valid !== 1'b0 || n_req !== base + 1) $display("FAIL dly_early_done got busy=%b v=%b n=%0d want 1/0/1", busy, mem_req_valid, n_req - base); else passed++;
    done();
    wait_idle();
    total++; if (n_req !== base + 2 || log_data[base+1] !== 32'd12) $display("FAIL dly_cmpl got n=%0d d=%h want 2/12", n_req - base, log_data[base+1]); else passed++;
  endtask
  task automatic test_back_to_back();
    int base = n_req;
    raise(3, 2);
    raise(7, 5);
    wait_valid();
    total++; if (irq_id !== 6'd7) $display("FAIL b2b_first got %0d want 7", irq_id); else passed++;
    ack();
    done();
    wait_idle();
    total++; if (busy !== 1'b0) $display("FAIL b2b_idle got busy=%b want 0", busy); else passed++;
    tick();
    total++; if (mem_req_valid !== 1'b1 || mem_req.req_type !== MEM_READ) $display("FAIL b2b_reclaim got v=%b want 1 read", mem_req_valid); else passed++;
    wait_valid();
    total++; if (irq_id !== 6'd3) $display("FAIL b2b_second got %0d want 3", irq_id); else passed++;
    ack();
    done();
    wait_idle();
    total++; if (n_req !== base + 4 || log_data[base+1] !== 32'd7 || log_data[base+3] !== 32'd3)
      $display("FAIL b2b_writes got n=%0d %h,%h want 4 7,3", n_req - base, log_data[base+1], log_data[base+3]); else passed++;
  endtask
  task automatic test_reset_mid();
    int base = n_req;
    raise(4, 1);
    wait_valid();
    ack();
    resp_stall = 1'b1;
    done();
    for (int i = 0; i < 20 && n_req != base + 2; i++) tick();
    total++; if (busy !== 1'b1 || mem_resp_ready !== 1'b1) $display("FAIL mid_in_resp got busy=%b rr=%b want 1/1", busy, mem_resp_ready); else passed++;
    rstn = 1'b0;
    #1;
    total++; if (irq_valid !== 1'b0 || mem_resp_ready !== 1'b0 || irq_id !== 6'd0) $display("FAIL mid_rst_out got iv=%b rr=%b id=%0d want 0", irq_valid, mem_resp_ready, irq_id); else passed++;
`ifndef PLIC_CLAIM_THRES_INIT_EN
    total++; if (busy !== 1'b0 || mem_req_valid !== 1'b0) $display("FAIL mid_rst_busy got busy=%b v=%b want 0/0", busy, mem_req_valid); else passed++;
`endif
    tick();
    rstn = 1'b1;
    resp_stall = 1'b0;
    repeat (5) tick();
`ifdef PLIC_CLAIM_THRES_INIT_EN
    total++; if (n_req !== base + 3 || log_addr[base+2] !== THRES_A) $display("FAIL mid_after got n=%0d a=%h want 3 %h", n_req - base, log_addr[base+2], THRES_A); else passed++;
`else
    total++; if (n_req !== base + 2 || busy !== 1'b0) $display("FAIL mid_after got n=%0d busy=%b want 2/0", n_req - base, busy); else passed++;
`endif
  endtask
  initial begin
    rstn = 1'b0;
    ext_force = 1'b0;
    irq_ready = 1'b0;
    irq_done = 1'b0;
    mem_req_ready = 1'b1;
    resp_stall = 1'b0;
    pend_tog = '0;
    for (int i = 0; i < 32; i++) prio[i] = 0;
    test_reset();
    test_basic();
    test_spurious();
    test_stall();
    test_deliver_delay();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
